// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared state encoding and default constants for the RO PUF controller
package ro_puf_pkg;

    // Measurement sequence: oscillators run through SETTLE and COUNT only.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        COUNT   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int CNT_W_DEF         = 16;
    localparam int WINDOW_CYCLES_DEF = 4096;
    localparam int SETTLE_CYCLES_DEF = 8;

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - 2-FF synchronizer, rising-edge detector and saturating edge counter
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   ro_in     - oscillator sample (asynchronous to clk)
//   clr       - synchronous clear of the count
//   cnt_en    - count detected rising edges while high
//   cnt       - current count, saturates at all-ones
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] cnt
);

    logic [1:0]       sync_q, sync_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The synchronizer and edge history run continuously so that by the time
    // counting is enabled the pipeline holds clean, settled samples.
    always_comb begin
        sync_d = {sync_q[0], ro_in};
        prev_d = sync_q[1];
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en && sync_q[1] && !prev_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ro_puf_ctrl.sv
// rtl/ro_puf_ctrl.sv - RO PUF sequencer: selects an oscillator pair, counts edges, emits a response bit
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start, sel_a, sel_b - measurement request and oscillator pair (sampled in IDLE)
//   ro_en               - oscillator enables, one-hot pair or zero
//   ro_out              - raw oscillator outputs (asynchronous)
//   busy                - measurement in progress
//   resp_valid          - one-cycle pulse, response fields valid
//   resp_bit/tie/err    - response: A faster / counts equal or saturated / bad selection
//   dbg_cnt_a/b         - final counts, present only when RO_PUF_CNT_DBG_EN is defined
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO        = 16,
    parameter int IDX_W         = $clog2(NUM_RO),
    parameter int CNT_W         = CNT_W_DEF,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  sel_a,
    input  logic [IDX_W-1:0]  sel_b,
    output logic [NUM_RO-1:0] ro_en,
    input  logic [NUM_RO-1:0] ro_out,
    output logic              busy,
    output logic              resp_valid,
    output logic              resp_bit,
    output logic              resp_tie,
    output logic              resp_err
`ifdef RO_PUF_CNT_DBG_EN
    ,
    output logic [CNT_W-1:0]  dbg_cnt_a,
    output logic [CNT_W-1:0]  dbg_cnt_b
`endif
);

    localparam logic [31:0] NUM_RO_U = 32'(NUM_RO);

    state_e            state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [IDX_W-1:0]  sel_a_q, sel_a_d;
    logic [IDX_W-1:0]  sel_b_q, sel_b_d;
    logic [NUM_RO-1:0] ro_en_q, ro_en_d;
    logic              resp_bit_q, resp_bit_d;
    logic              resp_tie_q, resp_tie_d;
    logic              resp_err_q, resp_err_d;
    logic              mux_a_q, mux_a_d;
    logic              mux_b_q, mux_b_d;

    logic [NUM_RO-1:0] pair_mask;
    logic              sel_ok;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cmp_tie;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;

    // Enable mask and validity of the requested pair, from the raw inputs so
    // the enables can be registered on the accepting edge.
    always_comb begin
        pair_mask = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            pair_mask[i] = (IDX_W'(i) == sel_a) || (IDX_W'(i) == sel_b);
        end
        sel_ok = (sel_a != sel_b) && (32'(sel_a) < NUM_RO_U) && (32'(sel_b) < NUM_RO_U);
    end

    // Registered oscillator muxes ahead of the per-channel synchronizers.
    always_comb begin
        mux_a_d = 1'b0;
        mux_b_d = 1'b0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (IDX_W'(i) == sel_a_q) mux_a_d = ro_out[i];
            if (IDX_W'(i) == sel_b_q) mux_b_d = ro_out[i];
        end
    end

    // A saturated counter no longer reflects relative frequency, so it is
    // reported as a tie rather than a possibly wrong ordering.
    assign cmp_tie = (cnt_a == cnt_b) || (&cnt_a) || (&cnt_b);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        ro_en_d    = ro_en_q;
        resp_bit_d = resp_bit_q;
        resp_tie_d = resp_tie_q;
        resp_err_d = resp_err_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_a_d    = sel_a;
                    sel_b_d    = sel_b;
                    resp_bit_d = 1'b0;
                    resp_tie_d = 1'b0;
                    if (sel_ok) begin
                        state_d    = SETTLE;
                        timer_d    = 32'(SETTLE_CYCLES - 1);
                        ro_en_d    = pair_mask;
                        resp_err_d = 1'b0;
                    end else begin
                        state_d    = DONE;
                        resp_err_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                cnt_clr = 1'b1;
                if (timer_q == '0) begin
                    state_d = COUNT;
                    timer_d = 32'(WINDOW_CYCLES - 1);
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            COUNT: begin
                cnt_en = 1'b1;
                if (timer_q == '0) begin
                    state_d = COMPARE;
                    ro_en_d = '0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            COMPARE: begin
                resp_bit_d = !cmp_tie && (cnt_a > cnt_b);
                resp_tie_d = cmp_tie;
                resp_err_d = 1'b0;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ro_en_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            sel_a_q    <= '0;
            sel_b_q    <= '0;
            ro_en_q    <= '0;
            resp_bit_q <= 1'b0;
            resp_tie_q <= 1'b0;
            resp_err_q <= 1'b0;
            mux_a_q    <= 1'b0;
            mux_b_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            ro_en_q    <= ro_en_d;
            resp_bit_q <= resp_bit_d;
            resp_tie_q <= resp_tie_d;
            resp_err_q <= resp_err_d;
            mux_a_q    <= mux_a_d;
            mux_b_q    <= mux_b_d;
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk    (clk),
        .rst    (reset),
        .ro_in  (mux_a_q),
        .clr    (cnt_clr),
        .cnt_en (cnt_en),
        .cnt    (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk    (clk),
        .rst    (reset),
        .ro_in  (mux_b_q),
        .clr    (cnt_clr),
        .cnt_en (cnt_en),
        .cnt    (cnt_b)
    );

`ifdef RO_PUF_CNT_DBG_EN
    logic [CNT_W-1:0] dbg_a_q, dbg_a_d;
    logic [CNT_W-1:0] dbg_b_q, dbg_b_d;

    always_comb begin
        dbg_a_d = dbg_a_q;
        dbg_b_d = dbg_b_q;
        if (state_q == IDLE && start) begin
            dbg_a_d = '0;
            dbg_b_d = '0;
        end else if (state_q == COMPARE) begin
            dbg_a_d = cnt_a;
            dbg_b_d = cnt_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_a_q <= '0;
            dbg_b_q <= '0;
        end else begin
            dbg_a_q <= dbg_a_d;
            dbg_b_q <= dbg_b_d;
        end
    end

    assign dbg_cnt_a = dbg_a_q;
    assign dbg_cnt_b = dbg_b_q;
`endif

    assign ro_en      = ro_en_q;
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_bit   = resp_bit_q;
    assign resp_tie   = resp_tie_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb/tb_ro_puf_ctrl.sv - self-checking bench for ro_puf_ctrl with behavioural ring oscillators
`timescale 1ns/1ps
module tb_ro_puf_ctrl;

    localparam int N = 16;
    // Oscillator periods in ps; 0/1 and 3/15 are identical (same phase) pairs.
    localparam int PER_PS [N] = '{40000, 40000, 50000, 30000, 60000, 70000, 80000, 32000,
                                  90000, 100000, 36000, 44000, 120000, 140000, 56000, 30000};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_m = 1'b0;
    logic          start_s = 1'b0;
    logic [3:0]    sel_a = '0;
    logic [3:0]    sel_b = '0;
    logic [N-1:0]  ro_en_m, ro_en_s, ro_out_m, ro_out_s;
    logic          busy_m, valid_m, bit_m, tie_m, err_m;
    logic          busy_s, valid_s, bit_s, tie_s, err_s;
    bit            use_small = 1'b0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_osc
        localparam int HALF_PS = PER_PS[g] / 2;
        logic o = 1'b0;
        initial begin
            #0.3;
            forever #(real'(HALF_PS) / 1000.0) o = ~o;
        end
        assign ro_out_m[g] = o & ro_en_m[g];
        assign ro_out_s[g] = o & ro_en_s[g];
    end

`ifdef RO_PUF_CNT_DBG_EN
    logic [15:0] dbg_a_m, dbg_b_m;
    logic [3:0]  dbg_a_s, dbg_b_s;
`endif

    ro_puf_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start_m), .sel_a(sel_a), .sel_b(sel_b),
        .ro_en(ro_en_m), .ro_out(ro_out_m), .busy(busy_m), .resp_valid(valid_m),
        .resp_bit(bit_m), .resp_tie(tie_m), .resp_err(err_m)
`ifdef RO_PUF_CNT_DBG_EN
        , .dbg_cnt_a(dbg_a_m), .dbg_cnt_b(dbg_b_m)
`endif
    );

    ro_puf_ctrl #(.CNT_W(4), .WINDOW_CYCLES(64)) u_dut_small (
        .clk(clk), .reset(reset), .start(start_s), .sel_a(sel_a), .sel_b(sel_b),
        .ro_en(ro_en_s), .ro_out(ro_out_s), .busy(busy_s), .resp_valid(valid_s),
        .resp_bit(bit_s), .resp_tie(tie_s), .resp_err(err_s)
`ifdef RO_PUF_CNT_DBG_EN
        , .dbg_cnt_a(dbg_a_s), .dbg_cnt_b(dbg_b_s)
`endif
    );

    logic [N-1:0] o_en;
    logic         o_busy, o_valid, o_bit, o_tie, o_err;
    assign o_en    = use_small ? ro_en_s : ro_en_m;
    assign o_busy  = use_small ? busy_s  : busy_m;
    assign o_valid = use_small ? valid_s : valid_m;
    assign o_bit   = use_small ? bit_s   : bit_m;
    assign o_tie   = use_small ? tie_s   : tie_m;
    assign o_err   = use_small ? err_s   : err_m;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (use_small) start_s = v;
        else           start_m = v;
    endtask

    // Expected edges in the window = window time / period; the faster
    // oscillator wins, equal estimates or a full counter give a tie.
    function automatic void predict(input int a, input int b, input int window, input int cmax,
                                    output bit eb, output bit et, output bit ee);
        int ca, cb;
        ee = (a == b);
        ca = (window * 10000) / PER_PS[a];
        cb = (window * 10000) / PER_PS[b];
        et = !ee && ((ca == cb) || (ca >= cmax) || (cb >= cmax));
        eb = !ee && !et && (ca > cb);
    endfunction

    task automatic run_meas(input int a, input int b, input bit extra, input string tag);
        int window, cmax, lat_exp, lat, nvalid, en_bad, busy_bad, k1;
        bit eb, et, ee, do_extra;
        logic [N-1:0] pair, exp_en;
        logic g_bit, g_tie, g_err;
        window = use_small ? 64 : 4096;
        cmax   = use_small ? 15 : 65535;
        predict(a, b, window, cmax, eb, et, ee);
        lat_exp  = ee ? 1 : (1 + 8 + window + 1);
        pair     = (N'(1) << a) | (N'(1) << b);
        do_extra = extra && !ee;
        k1       = ee ? 0 : int'($urandom_range(2, lat_exp - 2));
        lat = -1; nvalid = 0; en_bad = 0; busy_bad = 0;
        g_bit = 1'bx; g_tie = 1'bx; g_err = 1'bx;
        @(negedge clk);
        sel_a = 4'(a);
        sel_b = 4'(b);
        drive_start(1'b1);
        @(negedge clk);
        for (int cyc = 1; cyc <= lat_exp + 3; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (do_extra && (cyc == k1 || cyc == lat_exp)) begin
                sel_a = 4'($urandom);
                sel_b = 4'($urandom);
                drive_start(1'b1);
            end else begin
                drive_start(1'b0);
            end
            exp_en = (!ee && cyc <= lat_exp - 2) ? pair : '0;
            if (o_en !== exp_en) en_bad++;
            if (o_busy !== (cyc <= lat_exp)) busy_bad++;
            if (o_valid === 1'b1) begin
                nvalid++;
                if (lat < 0) begin
                    lat = cyc;
                    g_bit = o_bit; g_tie = o_tie; g_err = o_err;
                end
            end
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(lat_exp));
        check_eq({tag, ".n_valid"}, 32'(nvalid), 32'd1);
        check_eq({tag, ".ro_en_bad_cycles"}, 32'(en_bad), 32'd0);
        check_eq({tag, ".busy_bad_cycles"}, 32'(busy_bad), 32'd0);
        check_eq({tag, ".resp_bit"}, 32'(g_bit), 32'(eb));
        check_eq({tag, ".resp_tie"}, 32'(g_tie), 32'(et));
        check_eq({tag, ".resp_err"}, 32'(g_err), 32'(ee));
        check_eq({tag, ".hold"}, 32'({o_bit, o_tie, o_err}), 32'({eb, et, ee}));
    endtask

    initial begin
        int nv;
        repeat (3) @(negedge clk);
        check_eq("rst.ro_en", 32'(ro_en_m), 32'd0);
        check_eq("rst.busy", 32'(busy_m), 32'd0);
        check_eq("rst.resp_valid", 32'(valid_m), 32'd0);
        check_eq("rst.resp_bits", 32'({bit_m, tie_m, err_m}), 32'd0);
        check_eq("rst.small_ro_en", 32'(ro_en_s), 32'd0);
        reset = 1'b0;

        run_meas(3, 7, 1'b1, "a3b7");
        run_meas(7, 3, 1'b0, "a7b3");
        run_meas(5, 5, 1'b0, "same5");
        run_meas(0, 1, 1'b0, "tie01");

        use_small = 1'b1;
        run_meas(3, 12, 1'b1, "sat3_12");
        run_meas(8, 13, 1'b0, "s8_13");
        run_meas(13, 8, 1'b0, "s13_8");
        run_meas(9, 9, 1'b0, "s_same9");
        use_small = 1'b0;

        // Reset in the middle of COUNT aborts the measurement.
        @(negedge clk);
        sel_a = 4'd3;
        sel_b = 4'd7;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (2000) @(negedge clk);
        check_eq("abort.pre_ro_en", 32'(ro_en_m), 32'h0088);
        #2 reset = 1'b1;
        #1;
        check_eq("abort.ro_en", 32'(ro_en_m), 32'd0);
        check_eq("abort.busy", 32'(busy_m), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_m === 1'b1 || busy_m !== 1'b0) nv++;
        end
        check_eq("abort.no_activity", 32'(nv), 32'd0);
        run_meas(3, 7, 1'b0, "post_abort");

        for (int i = 0; i < 6; i++) begin
            int a, b;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            run_meas(a, b, ($urandom_range(0, 1) == 1), $sformatf("rnd%0d_a%0d_b%0d", i, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
